// File: rtl/inv_aes_128_iter_pkg.sv
// Shared AES constants and byte-level helpers for the iterative AES-128 decipher.
// Bytes are numbered FIPS-197 style: byte0 = [127:120], state is column-major.
package inv_aes_128_iter_pkg;

    localparam int BLK_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } st_t;

    // rcon[0..10]; entry 0 is never used by the key schedule
    localparam logic [87:0] AES_RCON = 88'h00_01_02_04_08_10_20_40_80_1b_36;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] aes_sbox(input logic [7:0] b);
        return SBOX[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] aes_inv_sbox(input logic [7:0] b);
        return INV_SBOX[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] aes_rcon(input logic [3:0] idx);
        return (idx > 4'd10) ? 8'h00 : AES_RCON[87 - 8*int'(idx) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Constant-operand GF(2^8) multiply; folds to XOR trees for fixed b
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Row r rotates right by r columns
    function automatic logic [BLK_W-1:0] inv_shift_rows(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] r;
        int src;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            src = (i % 4) + 4 * (((i / 4) + 4 - (i % 4)) % 4);
            r[127 - 8*i -: 8] = s[127 - 8*src -: 8];
        end
        return r;
    endfunction

    function automatic logic [BLK_W-1:0] inv_sub_bytes(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = aes_inv_sbox(s[127 - 8*i -: 8]);
        return r;
    endfunction

    function automatic logic [BLK_W-1:0] inv_mix_columns(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] r;
        logic [7:0] a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            r[127 - 32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            r[119 - 32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            r[111 - 32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            r[103 - 32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return r;
    endfunction

endpackage

// File: rtl/inv_aes_128_iter_key_step.sv
// Walks the AES-128 key schedule one round backwards: round-r key -> round-(r-1) key.
// Combinational; rconst must be rcon[r] for the incoming key.
module inv_key_step_128
    import inv_aes_128_iter_pkg::*;
(
    input  logic [BLK_W-1:0] key_in,
    input  logic [7:0]       rconst,
    output logic [BLK_W-1:0] key_out
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] v3, rot_v3, sub_v3;

    assign w0 = key_in[127:96];
    assign w1 = key_in[95:64];
    assign w2 = key_in[63:32];
    assign w3 = key_in[31:0];

    // v3 is the previous key's last word; it feeds SubWord(RotWord()) for v0
    assign v3     = w3 ^ w2;
    assign rot_v3 = {v3[23:0], v3[31:24]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sub_word
            assign sub_v3[8*gi +: 8] = aes_sbox(rot_v3[8*gi +: 8]);
        end
    endgenerate

    assign key_out = {w0 ^ sub_v3 ^ {rconst, 24'h000000}, w1 ^ w0, w2 ^ w1, v3};

endmodule

// File: rtl/inv_aes_128_iter.sv
// Iterative AES-128 decipher: one inverse round per clock, round keys regenerated
// backwards from the final round key. Valid/ready handshake on both sides.
module inv_aes_128_iter
    import inv_aes_128_iter_pkg::*;
#(
    parameter bit CLR_DATA = 1'b1
)
(
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] dat_in,
    input  logic [BLK_W-1:0] inv_key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] dat_out,
    output logic             busy
);

    st_t              st_reg, st_next;
    logic [BLK_W-1:0] s_reg, s_next;
    logic [BLK_W-1:0] k_reg, k_next;
    logic [BLK_W-1:0] dat_out_reg, dat_out_next;
    logic [3:0]       rnd_reg, rnd_next;
    logic [3:0]       rcon_idx;
    logic [7:0]       rconst;
    logic [BLK_W-1:0] k_prev;
    logic [BLK_W-1:0] round_t;

    assign rcon_idx = rnd_reg + 4'd1;
    assign rconst   = aes_rcon(rcon_idx);

    inv_key_step_128 u_key_step (
        .key_in  (k_reg),
        .rconst  (rconst),
        .key_out (k_prev)
    );

    assign round_t = inv_sub_bytes(inv_shift_rows(s_reg)) ^ k_prev;

    assign in_ready  = (st_reg == ST_IDLE) | ((st_reg == ST_DONE) & out_ready);
    assign out_valid = (st_reg == ST_DONE);
    assign busy      = (st_reg == ST_ROUND);
    assign dat_out   = dat_out_reg;

    always_comb begin
        st_next      = st_reg;
        s_next       = s_reg;
        k_next       = k_reg;
        rnd_next     = rnd_reg;
        dat_out_next = dat_out_reg;
        case (st_reg)
            ST_ROUND: begin
                k_next = k_prev;
                if (rnd_reg == 4'd0) begin
                    s_next       = round_t;
                    dat_out_next = round_t;
                    st_next      = ST_DONE;
                end else begin
                    s_next   = inv_mix_columns(round_t);
                    rnd_next = rnd_reg - 4'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) st_next = ST_IDLE;
            end
            default: st_next = ST_IDLE;
        endcase
        // A new block (from IDLE, or straight out of DONE on handoff) overrides the above
        if (in_valid && in_ready) begin
            s_next   = dat_in ^ inv_key;
            k_next   = inv_key;
            rnd_next = 4'd9;
            st_next  = ST_ROUND;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            st_reg  <= ST_IDLE;
            rnd_reg <= 4'd0;
            if (CLR_DATA) begin
                s_reg       <= '0;
                k_reg       <= '0;
                dat_out_reg <= '0;
            end
        end else begin
            st_reg      <= st_next;
            rnd_reg     <= rnd_next;
            s_reg       <= s_next;
            k_reg       <= k_next;
            dat_out_reg <= dat_out_next;
        end
    end

endmodule

// File: tb/tb_inv_aes_128_iter.sv
// Self-checking bench: a forward AES-128 model (S-box derived from GF(2^8) arithmetic)
// produces ciphertext and final round keys; the decipher must return the plaintext.
module tb_inv_aes_128_iter;

    logic         clk;
    logic         clr;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] dat_in;
    logic [127:0] inv_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] dat_out;
    logic         busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] sbox_tab [256];

    inv_aes_128_iter #(.CLR_DATA(1'b1)) dut (
        .clk       (clk),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dat_in    (dat_in),
        .inv_key   (inv_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dat_out   (dat_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int i = 0; i < 256; i++) begin
            inv = 8'h01;
            for (int j = 0; j < 254; j++) inv = gm(inv, 8'(i));
            if (i == 0) inv = 8'h00;
            sbox_tab[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic aes_enc(input logic [127:0] pt, input logic [127:0] key,
                           output logic [127:0] ct, output logic [127:0] last_key);
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   s [16];
        logic [7:0]   n [16];
        logic [127:0] rk;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]], sbox_tab[tmp[31:24]]}
                      ^ {rc, 24'h000000};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ key[127 - 8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_tab[s[i]];
            for (int i = 0; i < 16; i++) n[i] = s[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
            for (int c = 0; c < 4; c++) begin
                if (r < 10) begin
                    s[4*c]   = gm(n[4*c], 8'h02) ^ gm(n[4*c+1], 8'h03) ^ n[4*c+2] ^ n[4*c+3];
                    s[4*c+1] = n[4*c] ^ gm(n[4*c+1], 8'h02) ^ gm(n[4*c+2], 8'h03) ^ n[4*c+3];
                    s[4*c+2] = n[4*c] ^ n[4*c+1] ^ gm(n[4*c+2], 8'h02) ^ gm(n[4*c+3], 8'h03);
                    s[4*c+3] = gm(n[4*c], 8'h03) ^ n[4*c+1] ^ n[4*c+2] ^ gm(n[4*c+3], 8'h02);
                end else begin
                    for (int j = 0; j < 4; j++) s[4*c+j] = n[4*c+j];
                end
            end
            rk = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127 - 8*i -: 8];
        end
        for (int i = 0; i < 16; i++) ct[127 - 8*i -: 8] = s[i];
        last_key = {w[40], w[41], w[42], w[43]};
    endtask

    task automatic gen_block(output logic [127:0] pt, output logic [127:0] ct, output logic [127:0] k10);
        logic [127:0] key;
        pt  = {$urandom, $urandom, $urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
        aes_enc(pt, key, ct, k10);
    endtask

    // ---------------- drivers (no checking) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_block(input logic [127:0] ct, input logic [127:0] key, output bit ok);
        dat_in   = ct;
        inv_key  = key;
        in_valid = 1'b1;
        ok       = 1'b0;
        #1;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (in_ready) ok = 1'b1;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clr = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dat_in = '0; inv_key = '0;
        tick(); tick();
        clr = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || dat_out !== 128'h0) begin
            errors++;
            $display("FAIL reset got ir=%b ov=%b busy=%b dat=%h exp ir=1 ov=0 busy=0 dat=0",
                     in_ready, out_valid, busy, dat_out);
        end
        $display("reset: ir=%b ov=%b busy=%b", in_ready, out_valid, busy);
    endtask

    task automatic test_known_answer();
        logic [127:0] cts [2];
        logic [127:0] kys [2];
        logic [127:0] pts [2];
        bit ok;
        int n;
        cts[0] = 128'h3925841d02dc09fbdc118597196a0b32;
        kys[0] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        pts[0] = 128'h3243f6a8885a308d313198a2e0370734;
        cts[1] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        kys[1] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        pts[1] = 128'h00112233445566778899aabbccddeeff;
        for (int v = 0; v < 2; v++) begin
            out_ready = 1'b0;
            accept_block(cts[v], kys[v], ok);
            checks++;
            if (!ok || busy !== 1'b1) begin
                errors++;
                $display("FAIL kat%0d_accept got ok=%b busy=%b exp ok=1 busy=1", v, ok, busy);
            end
            wait_out(n);
            checks++;
            if (n != 10) begin
                errors++;
                $display("FAIL kat%0d_latency got %0d exp 10", v, n);
            end
            checks++;
            if (dat_out !== pts[v]) begin
                errors++;
                $display("FAIL kat%0d_data got %h exp %h", v, dat_out, pts[v]);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            checks++;
            if (out_valid !== 1'b0 || dat_out !== pts[v] || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL kat%0d_handoff got ov=%b ir=%b dat=%h exp ov=0 ir=1 dat=%h",
                         v, out_valid, in_ready, dat_out, pts[v]);
            end
            $display("kat%0d: ct=%h pt=%h latency=%0d", v, cts[v], dat_out, n);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] pts [10];
        logic [127:0] cts [10];
        logic [127:0] kys [10];
        int acc_cyc [10];
        int cyc, in_idx, out_idx, idle;
        bit acc;
        for (int i = 0; i < 10; i++) gen_block(pts[i], cts[i], kys[i]);
        cyc = 0; in_idx = 0; out_idx = 0; idle = 0;
        dat_in = cts[0]; inv_key = kys[0]; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        while (out_idx < 10 && cyc < 400) begin
            if (in_idx > 0 && !busy && !out_valid) idle++;
            if (out_valid) begin
                checks++;
                if (dat_out !== pts[out_idx] || cyc != acc_cyc[out_idx] + 10) begin
                    errors++;
                    $display("FAIL b2b_block%0d got dat=%h lat=%0d exp dat=%h lat=10",
                             out_idx, dat_out, cyc - acc_cyc[out_idx], pts[out_idx]);
                end
                $display("b2b block %0d: pt=%h at edge %0d", out_idx, dat_out, cyc);
                out_idx++;
            end
            acc = in_valid && in_ready;
            tick();
            cyc++;
            if (acc) begin
                acc_cyc[in_idx] = cyc;
                in_idx++;
                if (in_idx < 10) begin
                    dat_in = cts[in_idx];
                    inv_key = kys[in_idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if (out_idx != 10) begin
            errors++;
            $display("FAIL b2b_count got %0d exp 10", out_idx);
        end
        checks++;
        if (idle != 0) begin
            errors++;
            $display("FAIL b2b_idle got %0d exp 0", idle);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] pa, ca, ka, pb, cb, kb;
        bit ok;
        int n;
        gen_block(pa, ca, ka);
        gen_block(pb, cb, kb);
        out_ready = 1'b0;
        accept_block(ca, ka, ok);
        wait_out(n);
        checks++;
        if (!ok || n != 10 || dat_out !== pa) begin
            errors++;
            $display("FAIL bp_first got ok=%b lat=%0d dat=%h exp ok=1 lat=10 dat=%h", ok, n, dat_out, pa);
        end
        dat_in = cb; inv_key = kb; in_valid = 1'b1;
        for (int i = 0; i < 25; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || dat_out !== pa || in_ready !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cyc %0d got ov=%b ir=%b busy=%b dat=%h exp ov=1 ir=0 busy=0 dat=%h",
                         i, out_valid, in_ready, busy, dat_out, pa);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready got %b exp 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_second_accept got ov=%b busy=%b exp ov=0 busy=1", out_valid, busy);
        end
        wait_out(n);
        checks++;
        if (n != 10 || dat_out !== pb) begin
            errors++;
            $display("FAIL bp_second got lat=%0d dat=%h exp lat=10 dat=%h", n, dat_out, pb);
        end
        $display("backpressure: a=%h b=%h", pa, dat_out);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_clr_mid_round();
        logic [127:0] ct, ky, pt;
        bit ok, seen;
        int n;
        ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        ky = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        pt = 128'h00112233445566778899aabbccddeeff;
        accept_block(ct, ky, ok);
        for (int i = 0; i < 4; i++) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || dat_out !== 128'h0) begin
            errors++;
            $display("FAIL clr_mid got busy=%b ov=%b ir=%b dat=%h exp busy=0 ov=0 ir=1 dat=0",
                     busy, out_valid, in_ready, dat_out);
        end
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL clr_mid_discard got out_valid=1 exp 0");
        end
        accept_block(ct, ky, ok);
        wait_out(n);
        checks++;
        if (!ok || n != 10 || dat_out !== pt) begin
            errors++;
            $display("FAIL clr_mid_next got ok=%b lat=%0d dat=%h exp ok=1 lat=10 dat=%h", ok, n, dat_out, pt);
        end
        $display("clr mid-round: next block pt=%h", dat_out);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_clr_with_valid();
        bit seen;
        dat_in   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        inv_key  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        in_valid = 1'b1;
        clr      = 1'b1;
        tick();
        clr      = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clr_valid got ir=%b busy=%b exp ir=1 busy=0", in_ready, busy);
        end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid || busy) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL clr_valid_ignored got activity=1 exp 0");
        end
        $display("clr with in_valid: ir=%b busy=%b", in_ready, busy);
    endtask

    initial begin
        clr = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dat_in = '0; inv_key = '0;
        build_sbox();
        test_reset();
        test_known_answer();
        test_back_to_back();
        test_backpressure();
        test_clr_mid_round();
        test_clr_with_valid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
